td_batch_scheduler: RTL and testbench
=====================================

// Module: td_batch_scheduler
// PURPOSE
//  Sequences one replay mini-batch through the FP32 TD-error unit (gamma*Qmax + reward - Q).
//  Fetches samples from sample RAM, issues them at a safe spacing, collects TD results in order
//  into a ready/valid result FIFO, and tags each result with its batch index.
//  Sits between the replay memory and the DQN weight-update stage.
// PARAMETERS
//  BATCH_MAX  32  maximum batch length; index width IDX_W = $clog2(BATCH_MAX)
//  LOSS_LAT   22  TD unit latency, loss_valid_in to loss_valid_out (3 x 7-cycle FP ops + 1 reg)
//  ISSUE_GAP  15  minimum cycles between loss_valid_in pulses; TD unit holds reward/Q in one register
//  RES_DEPTH  4   result FIFO depth; power of 2
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       reset, synchronous, active-high
//  start          in   1       begin batch; sampled only in IDLE
//  batch_len      in   IDX_W+1 samples in batch (0..BATCH_MAX); latched on start
//  gamma          in   32      FP32 discount; latched on start
//  smp_rd_en      out  1       sample RAM read strobe
//  smp_rd_addr    out  IDX_W   sample index
//  smp_rd_data    in   96      {Qmax, reward, Q}; valid 1 cycle after smp_rd_en
//  loss_valid_in  out  1       one-cycle issue pulse to TD unit
//  loss_gamma/loss_qmax/loss_reward/loss_q  out 32 each  operands; held stable until next issue
//  loss_valid_out in   1       TD result valid
//  loss_td        in   32      TD result, FP32
//  td_valid       out  1       result available
//  td_ready       in   1       consumer accepts when td_valid & td_ready
//  td_data        out  32      TD value (clipped when TD_CLIP_EN)
//  td_index       out  IDX_W   batch index of td_data
//  td_last        out  1       td_index == batch_len-1
//  busy           out  1       state != IDLE
//  done           out  1       one-cycle pulse when batch fully delivered
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters, FIFO and credits cleared.
//  FSM: IDLE -start-> FETCH (len>0) | DONE (len==0).
//   FETCH: smp_rd_en=1, addr=issue_idx; -> ISSUE.
//   ISSUE: register operands, loss_valid_in=1, issue_idx++, gap_cnt=ISSUE_GAP-1; -> WAIT.
//   WAIT: gap_cnt counts down; -> FETCH when gap_cnt==0 and inflight+fifo_count < RES_DEPTH
//     and issue_idx < len; -> DRAIN when all samples have been issued.
//   DRAIN: -> DONE when inflight==0, fifo empty, and last result popped.
//   DONE: done=1 for one cycle; -> IDLE.
//  Timing: start at cycle 0 -> smp_rd_en at cycle 1 -> loss_valid_in at cycle 2 -> result at 2+LOSS_LAT.
//  Credits: inflight++ on issue, inflight-- on loss_valid_out; same-cycle issue and result leaves it
//   unchanged. Credit rule guarantees no FIFO overflow; an overflow is a simulation assertion error.
//  Results are returned in order; td_index = result counter, incremented on each FIFO push.
//  FIFO push and pop in the same cycle are allowed when full or empty-with-bypass-off (no bypass;
//   first-word latency 1 cycle).
//  start while busy is ignored. loss_valid_out in IDLE is dropped.
//  Reset mid-batch discards all state. The TD unit must be reset in the same cycle.
//  gamma/batch_len changes after start have no effect.
// CONFIGURATION
//  TD_CLIP_EN defined: before the FIFO push, the TD value is clamped to [-1,+1] (Huber-style).
//   If exp field >= 8'd127, output {sign, 31'h3F800000}; NaN passes unchanged.
//  TD_CLIP_EN undefined: loss_td is stored unmodified; there is no clip logic.
// STRUCTURE
//  Package dqn_pkg: FP_ONE=32'h3F800000, FP_EXP_BIAS=8'd127, typedef replay_sample_t {qmax,reward,q},
//   typedef td_sched_state_e {IDLE,FETCH,ISSUE,WAIT,DRAIN,DONE}.
//  Sub-module td_result_fifo (width 32+IDX_W, depth RES_DEPTH, sync, count output).
// TESTING
//  1. gamma=3F000000, every sample {Qmax=40000000, reward=3F800000, Q=3F000000}, len=4, ready=1
//     -> 4 results 3FC00000, indices 0..3, td_last on index 3, one done pulse.
//  2. Same stimulus as 1 with TD_CLIP_EN -> results 3F800000; Q=40800000 -> BF800000.
//  3. len=8, monitor loss_valid_in -> pulses exactly ISSUE_GAP+2=17 cycles apart, first at cycle 2.
//  4. len=8, td_ready=0 for 200 cycles -> issues stop at RES_DEPTH outstanding, no drop;
//     ready=1 -> 8 results in order.
//  5. len=0 -> no smp_rd_en or loss_valid_in; done at cycle 1; start while busy ignored.
//  6. rst asserted after 3rd issue -> all outputs 0 next cycle; new batch runs clean.

Source files
------------

// File: rtl/dqn_pkg.sv
// Shared types and constants for the DQN TD-error batch scheduler.
// Optional build macro TD_CLIP_EN adds the [-1,+1] TD clamp helper.
package dqn_pkg;

    localparam int BATCH_MAX = 32;
    localparam int IDX_W     = $clog2(BATCH_MAX);
    localparam int LOSS_LAT  = 22;
    localparam int ISSUE_GAP = 15;
    localparam int RES_DEPTH = 4;
    localparam int CNT_W     = $clog2(RES_DEPTH) + 1;

    localparam logic [31:0] FP_ONE      = 32'h3F800000;
    localparam logic [7:0]  FP_EXP_BIAS = 8'd127;

    typedef struct packed {
        logic [31:0] qmax;
        logic [31:0] reward;
        logic [31:0] q;
    } replay_sample_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } td_sched_state_e;

`ifdef TD_CLIP_EN
    // Any magnitude >= 1.0 (including infinity) saturates to +/-1.0; NaN passes through.
    function automatic logic [31:0] fp_clip_unit(input logic [31:0] x);
        logic [31:0] y;
        if ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0)) begin
            y = x;
        end else if (x[30:23] >= FP_EXP_BIAS) begin
            y = {x[31], FP_ONE[30:0]};
        end else begin
            y = x;
        end
        return y;
    endfunction
`endif

endpackage

// File: rtl/td_result_fifo.sv
// Synchronous result FIFO with occupancy count; no bypass, so first-word latency is one cycle.
// Overflow is flagged by a companion checker module.
module td_result_fifo_chk (
    input logic clk,
    input logic rst,
    input logic push_i,
    input logic full_i,
    input logic pop_i
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full_i && !pop_i));
endmodule

module td_result_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_s, empty_s, do_push_s, do_pop_s;

    assign full_s    = (cnt_q == CNT_W'(DEPTH));
    assign empty_s   = (cnt_q == '0);
    assign do_pop_s  = pop_i && !empty_s;
    assign do_push_s = push_i && (!full_s || do_pop_s);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push_s) begin
            wr_d = wr_q + AW'(1);
        end else begin
            wr_d = wr_q;
        end
        if (do_pop_s) begin
            rd_d = rd_q + AW'(1);
        end else begin
            rd_d = rd_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push_s) mem_q[wr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_q];
    assign valid_o    = !empty_s;
    assign count_o    = cnt_q;

    td_result_fifo_chk u_chk (
        .clk    (clk),
        .rst    (rst),
        .push_i (push_i),
        .full_i (full_s),
        .pop_i  (do_pop_s)
    );
endmodule

// File: rtl/td_batch_scheduler.sv
// Sequences one replay mini-batch through the TD-error unit and returns tagged results in order.
// Build macro TD_CLIP_EN clamps TD values to [-1,+1] before they enter the result FIFO.
module td_batch_scheduler
    import dqn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W:0]   batch_len,
    input  logic [31:0]      gamma,
    output logic             smp_rd_en,
    output logic [IDX_W-1:0] smp_rd_addr,
    input  logic [95:0]      smp_rd_data,
    output logic             loss_valid_in,
    output logic [31:0]      loss_gamma,
    output logic [31:0]      loss_qmax,
    output logic [31:0]      loss_reward,
    output logic [31:0]      loss_q,
    input  logic             loss_valid_out,
    input  logic [31:0]      loss_td,
    output logic             td_valid,
    input  logic             td_ready,
    output logic [31:0]      td_data,
    output logic [IDX_W-1:0] td_index,
    output logic             td_last,
    output logic             busy,
    output logic             done
);
    localparam int FW    = 32 + IDX_W;
    localparam int GAP_W = $clog2(ISSUE_GAP);

    td_sched_state_e  state_q, state_d;
    logic [IDX_W:0]   len_q, len_d, issue_idx_q, issue_idx_d;
    logic [31:0]      gamma_q, gamma_d;
    logic [IDX_W-1:0] res_idx_q, res_idx_d, rd_addr_q, rd_addr_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    replay_sample_t   op_q, op_d, smp_s;
    logic             rd_en_q, rd_en_d, lvi_q, lvi_d, done_q, done_d, busy_q, busy_d;

    logic             issue_s, result_s, pop_s, credit_ok_s, fifo_valid_s;
    logic [31:0]      push_td_s;
    logic [FW-1:0]    fifo_out_s;
    logic [CNT_W-1:0] fifo_cnt_s;

    assign smp_s       = smp_rd_data;
    assign issue_s     = (state_q == ISSUE);
    assign result_s    = loss_valid_out && (state_q != IDLE);
    assign pop_s       = fifo_valid_s && td_ready;
    assign credit_ok_s = ({1'b0, inflight_q} + {1'b0, fifo_cnt_s}) < (CNT_W + 1)'(RES_DEPTH);

`ifdef TD_CLIP_EN
    assign push_td_s = fp_clip_unit(loss_td);
`else
    assign push_td_s = loss_td;
`endif

    // Next-state, counters, credits and registered-output next values.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        gamma_d     = gamma_q;
        issue_idx_d = issue_idx_q;
        gap_d       = gap_q;
        op_d        = op_q;
        inflight_d  = inflight_q;
        res_idx_d   = res_idx_q;

        case ({issue_s, result_s})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        if (result_s) begin
            res_idx_d = res_idx_q + IDX_W'(1);
        end else begin
            res_idx_d = res_idx_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d       = batch_len;
                    gamma_d     = gamma;
                    issue_idx_d = '0;
                    res_idx_d   = '0;
                    inflight_d  = '0;
                    state_d     = (batch_len == '0) ? DONE : FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: state_d = ISSUE;
            ISSUE: begin
                op_d        = smp_s;
                issue_idx_d = issue_idx_q + (IDX_W + 1)'(1);
                gap_d       = GAP_W'(ISSUE_GAP - 1);
                state_d     = WAIT;
            end
            WAIT: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else begin
                    gap_d = gap_q;
                end
                if (issue_idx_q == len_q) begin
                    state_d = DRAIN;
                end else if ((gap_q == '0) && credit_ok_s) begin
                    state_d = FETCH;
                end else begin
                    state_d = WAIT;
                end
            end
            DRAIN: begin
                if ((inflight_q == '0) && (fifo_cnt_s == '0)) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rd_en_d = (state_d == FETCH);
        lvi_d   = (state_d == ISSUE);
        done_d  = (state_d == DONE);
        busy_d  = (state_d != IDLE);
        if (state_d == FETCH) begin
            rd_addr_d = issue_idx_d[IDX_W-1:0];
        end else begin
            rd_addr_d = rd_addr_q;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            gamma_q     <= '0;
            issue_idx_q <= '0;
            gap_q       <= '0;
            op_q        <= '0;
            inflight_q  <= '0;
            res_idx_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            lvi_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            gamma_q     <= gamma_d;
            issue_idx_q <= issue_idx_d;
            gap_q       <= gap_d;
            op_q        <= op_d;
            inflight_q  <= inflight_d;
            res_idx_q   <= res_idx_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            lvi_q       <= lvi_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    td_result_fifo #(
        .WIDTH (FW),
        .DEPTH (RES_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (result_s),
        .push_data_i ({res_idx_q, push_td_s}),
        .pop_i       (pop_s),
        .pop_data_o  (fifo_out_s),
        .valid_o     (fifo_valid_s),
        .count_o     (fifo_cnt_s)
    );

    // RAM data lands in the ISSUE cycle, so operands bypass the hold register while issuing.
    assign loss_qmax     = issue_s ? smp_s.qmax   : op_q.qmax;
    assign loss_reward   = issue_s ? smp_s.reward : op_q.reward;
    assign loss_q        = issue_s ? smp_s.q      : op_q.q;
    assign loss_gamma    = gamma_q;
    assign loss_valid_in = lvi_q;
    assign smp_rd_en     = rd_en_q;
    assign smp_rd_addr   = rd_addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign td_valid      = fifo_valid_s;
    assign td_data       = fifo_out_s[31:0];
    assign td_index      = fifo_out_s[FW-1:32];
    assign td_last       = fifo_valid_s && ({1'b0, td_index} == (len_q - {{IDX_W{1'b0}}, 1'b1}));
endmodule

// File: tb/tb_td_batch_scheduler.sv
// Self-checking bench for td_batch_scheduler: behavioural sample RAM and TD unit, table of batches,
// scoreboard of expected results, plus hand sequences for backpressure, empty batch and reset.
module tb_td_batch_scheduler;
    import dqn_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [IDX_W:0]   batch_len = '0;
    logic [31:0]      gamma = '0;
    logic             smp_rd_en;
    logic [IDX_W-1:0] smp_rd_addr;
    logic [95:0]      smp_rd_data = '0;
    logic             loss_valid_in;
    logic [31:0]      loss_gamma, loss_qmax, loss_reward, loss_q;
    logic             loss_valid_out;
    logic [31:0]      loss_td;
    logic             td_valid;
    logic             td_ready = 1'b0;
    logic [31:0]      td_data;
    logic [IDX_W-1:0] td_index;
    logic             td_last, busy, done;

    always #5 clk = ~clk;

    td_batch_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .batch_len(batch_len), .gamma(gamma),
        .smp_rd_en(smp_rd_en), .smp_rd_addr(smp_rd_addr), .smp_rd_data(smp_rd_data),
        .loss_valid_in(loss_valid_in), .loss_gamma(loss_gamma), .loss_qmax(loss_qmax),
        .loss_reward(loss_reward), .loss_q(loss_q), .loss_valid_out(loss_valid_out),
        .loss_td(loss_td), .td_valid(td_valid), .td_ready(td_ready), .td_data(td_data),
        .td_index(td_index), .td_last(td_last), .busy(busy), .done(done)
    );

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        m = m * (2.0 ** e);
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real         a;
        int          e;
        logic        s;
        logic [22:0] mt;
        logic [7:0]  ex;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        mt = 23'($rtoi((a - 1.0) * 8388608.0));
        ex = 8'(e + 127);
        return {s, ex, mt};
    endfunction

    function automatic logic [31:0] exp_out(input logic [31:0] x);
`ifdef TD_CLIP_EN
        if ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0)) return x;
        if (x[30:23] >= 8'd127) return {x[31], 31'h3F800000};
        return x;
`else
        return x;
`endif
    endfunction

    // Sample RAM: registered read, data valid the cycle after smp_rd_en.
    logic [95:0] smp_mem [BATCH_MAX];
    always @(posedge clk) if (smp_rd_en) smp_rd_data <= smp_mem[smp_rd_addr];

    // TD unit: gamma*Qmax + reward - Q, LOSS_LAT cycles from loss_valid_in to loss_valid_out.
    logic [LOSS_LAT-1:0] tv_q;
    logic [31:0]         tdat_q [LOSS_LAT];
    always @(posedge clk) begin
        if (rst) begin
            tv_q <= '0;
        end else begin
            tv_q      <= {tv_q[LOSS_LAT-2:0], loss_valid_in};
            tdat_q[0] <= r2f(f2r(loss_gamma) * f2r(loss_qmax) + f2r(loss_reward) - f2r(loss_q));
            for (int i = 1; i < LOSS_LAT; i++) tdat_q[i] <= tdat_q[i-1];
        end
    end
    assign loss_valid_out = tv_q[LOSS_LAT-1];
    assign loss_td        = tdat_q[LOSS_LAT-1];

    typedef struct {
        logic [31:0] g, qmax, rw, q;
        int          len;
        bit          vary;
        bit          rnd_rdy;
        logic [31:0] exp_td;
    } vec_t;

    typedef struct packed {
        logic [31:0]      td;
        logic [IDX_W-1:0] idx;
        logic             last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0, checks = 0;
    int   cyc = 0, start_cyc = 0;
    int   lvi_cnt, rd_cnt, done_cnt, first_lvi, first_rd, first_res, done_cyc, last_lvi;
    bit   chk_gap = 1'b0, rnd_rdy = 1'b0, force_rdy = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        td_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
    end

    // Output monitor and scoreboard consumer, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (smp_rd_en) begin
                if (rd_cnt == 0) first_rd = cyc;
                rd_cnt++;
            end
            if (loss_valid_in) begin
                if (lvi_cnt == 0) first_lvi = cyc;
                else if (chk_gap) chk("issue_gap", cyc - last_lvi, ISSUE_GAP + 2);
                last_lvi = cyc;
                lvi_cnt++;
            end
            if (done) begin
                if (done_cnt == 0) done_cyc = cyc;
                done_cnt++;
            end
            if (td_valid && first_res < 0) first_res = cyc;
            if (td_valid && td_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got idx %0d data %h, expected none", td_index, td_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk("td_data", td_data, mon_e.td);
                    chk("td_index", 32'(td_index), 32'(mon_e.idx));
                    chk("td_last", 32'(td_last), 32'(mon_e.last));
                end
            end
        end
    end

    task automatic start_batch(input vec_t v);
        for (int i = 0; i < v.len; i++) begin
            logic [31:0] rw;
            logic [31:0] ex;
            exp_t        e;
            // Varying rows use gamma=0.5, Qmax=2, Q=0.5 and reward=i, so TD = i + 0.5.
            rw = v.vary ? r2f(real'(i)) : v.rw;
            ex = v.vary ? r2f(real'(i) + 0.5) : v.exp_td;
            smp_mem[i] = {v.qmax, rw, v.q};
            e.td   = exp_out(ex);
            e.idx  = IDX_W'(i);
            e.last = (i == v.len - 1);
            sb.push_back(e);
        end
        gamma     = v.g;
        batch_len = (IDX_W + 1)'(v.len);
        lvi_cnt = 0; rd_cnt = 0; done_cnt = 0;
        first_lvi = -1; first_rd = -1; first_res = -1; done_cyc = -1;
        @(posedge clk);
        #1;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start     = 1'b0;
        gamma     = $urandom;
        batch_len = (IDX_W + 1)'($urandom_range(0, BATCH_MAX));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done_cnt != 0), 32'd1);
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt, 1);
        chk("idle_after", 32'(busy), 32'd0);
        chk("sb_empty", sb.size(), 0);
    endtask

    vec_t vt[5];
    vec_t z;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{32'h3F000000, 32'h40000000, 32'h3F800000, 32'h3F000000, 4, 1'b0, 1'b0, 32'h3FC00000};
        vt[1] = '{32'h3F800000, 32'h3F800000, 32'h00000000, 32'h40000000, 1, 1'b0, 1'b1, 32'hBF800000};
        vt[2] = '{32'h3F000000, 32'h3F800000, 32'h3E800000, 32'h3F000000, BATCH_MAX, 1'b0, 1'b1, 32'h3E800000};
        vt[3] = '{32'h3F000000, 32'h40000000, 32'h3F800000, 32'h40800000, 3, 1'b0, 1'b0, 32'hC0000000};
        vt[4] = '{32'h3F000000, 32'h40000000, 32'h00000000, 32'h3F000000, 8, 1'b1, 1'b0, 32'h00000000};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ctl", 32'({busy, done, td_valid, td_last, smp_rd_en, loss_valid_in}), 32'd0);
        chk("reset_data", td_data | loss_q | loss_gamma | loss_qmax | loss_reward, 32'd0);

        for (int v = 0; v < 5; v++) begin
            rnd_rdy   = vt[v].rnd_rdy;
            force_rdy = 1'b1;
            chk_gap   = !vt[v].rnd_rdy;
            start_batch(vt[v]);
            wait_done(4000);
            chk("issue_count", lvi_cnt, vt[v].len);
            chk("fetch_count", rd_cnt, vt[v].len);
            chk("first_fetch_cyc", first_rd - start_cyc, 1);
            chk("first_issue_cyc", first_lvi - start_cyc, 2);
            chk("first_result_cyc", first_res - start_cyc, LOSS_LAT + 3);
        end

        // Backpressure: issues must stall at RES_DEPTH outstanding without losing results.
        rnd_rdy = 1'b0; force_rdy = 1'b0; chk_gap = 1'b0;
        start_batch(vt[4]);
        repeat (200) @(negedge clk);
        chk("bp_issue_count", lvi_cnt, RES_DEPTH);
        chk("bp_valid", 32'(td_valid), 32'd1);
        chk("bp_no_pop", sb.size(), 8);
        chk("bp_busy", 32'(busy), 32'd1);
        force_rdy = 1'b1;
        wait_done(2000);
        chk("bp_total_issues", lvi_cnt, 8);

        // Empty batch: straight to DONE with no fetch or issue.
        z = '{32'h3F000000, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0};
        start_batch(z);
        wait_done(20);
        chk("len0_done_cyc", done_cyc - start_cyc, 1);
        chk("len0_no_fetch", rd_cnt, 0);
        chk("len0_no_issue", lvi_cnt, 0);

        // start while busy is ignored.
        chk_gap = 1'b1;
        start_batch(vt[0]);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1;
        start = 1'b1; batch_len = (IDX_W + 1)'(2); gamma = 32'h40000000;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1000);
        chk("busy_start_issues", lvi_cnt, 4);
        repeat (5) @(negedge clk);
        chk("busy_start_no_rerun", done_cnt, 1);

        // Reset mid-batch after the third issue, then a clean batch.
        start_batch(vt[4]);
        begin
            int n = 0;
            while (lvi_cnt < 3 && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        chk("third_issue_seen", lvi_cnt, 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        chk("midrst_ctl", 32'({busy, done, td_valid, td_last, smp_rd_en, loss_valid_in}), 32'd0);
        chk("midrst_data", td_data | loss_q | loss_gamma | loss_qmax | loss_reward, 32'd0);
        chk("midrst_idx", 32'({td_index, smp_rd_addr}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_batch(vt[0]);
        wait_done(1000);
        chk("post_rst_issues", lvi_cnt, 4);
        chk("post_rst_first_issue", first_lvi - start_cyc, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
